// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its queue.
package instruction_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO of fetched {pc, instr} pairs with synchronous flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
    end
  end

  // Storage is data only; pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush && !i_rst) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch unit: PC register and single-outstanding request FSM feeding a decode queue.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  output logic                         mem_req,
  output logic [31:0]                  mem_addr,
  input  logic                         mem_valid,
  input  logic [31:0]                  mem_data,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         decode_ready,
  output logic                         decodePulse,
  output logic [31:0]                  instr,
  output logic [31:0]                  pcNumber,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_hold_pc;
  logic [31:0]  r_hold_instr;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_full;
  logic         w_empty;
  fetch_entry_t w_head;
  fetch_entry_t w_push_entry;
  logic         w_unused;

  assign w_unused     = ^redirect_pc[1:0];
  assign w_flush      = redirect && !reset;
  assign w_push       = (r_state == S_WAIT) && mem_valid && !redirect && !reset;
  assign w_pop        = !w_empty && decode_ready && !redirect && !reset;
  assign w_push_entry = '{pc: r_pc, instr: mem_data};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH (64)
  ) u_queue (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  (w_push_entry),
    .o_head  (w_head),
    .o_count (queue_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_REQ;
    else       r_state <= w_next_state;
  end

  // A redirect with a response still in flight must swallow that response in DROP.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_REQ: begin
        if (!redirect && !w_full) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (mem_valid)     w_next_state = S_REQ;
        else if (redirect) w_next_state = S_DROP;
      end
      S_DROP: begin
        if (mem_valid) w_next_state = S_REQ;
      end
      default: w_next_state = S_REQ;
    endcase
  end

  always_comb begin
    mem_req  = (r_state == S_REQ) && !w_full && !redirect && !reset;
    mem_addr = r_pc;
  end

  always_ff @(posedge clock) begin
    if (reset)         r_pc <= RESET_PC;
    else if (redirect) r_pc <= align_pc(redirect_pc);
    else if (w_push)   r_pc <= r_pc + 32'd4;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
    end else if (w_pop) begin
      r_hold_pc    <= w_head.pc;
      r_hold_instr <= w_head.instr;
    end
  end

  // Head is presented combinationally on the pop cycle, then held afterwards.
  assign decodePulse = w_pop;
  assign instr       = w_pop ? w_head.instr : r_hold_instr;
  assign pcNumber    = w_pop ? w_head.pc    : r_hold_pc;

endmodule
